// File: rtl/reg_bank_encap_if.sv
// Register bank bus interface: control strobes, instruction/ALU inputs and the
// always-driven read ports. The tristate B/C buses are shared nets and stay
// plain ports on the register bank.
interface reg_bank_encap_if;
  logic        LATCH_REG;
  logic        IR_RD_MUX;
  logic        LSM_RD_MUX;
  logic        RD_MUX;
  logic        PC_MUX;
  logic        DATA_MUX;
  logic        REG_GATE_B;
  logic        REG_GATE_C;
  logic [31:0] IR;
  logic [31:0] ALU_BUS;
  logic [3:0]  REG_COUNTER;
  logic [31:0] A_BUS;
  logic [31:0] ST;
  logic [31:0] PC;

  // Controller / datapath side
  modport master (
    output LATCH_REG, IR_RD_MUX, LSM_RD_MUX, RD_MUX, PC_MUX, DATA_MUX,
    output REG_GATE_B, REG_GATE_C, IR, ALU_BUS, REG_COUNTER,
    input  A_BUS, ST, PC
  );

  // Register bank side
  modport slave (
    input  LATCH_REG, IR_RD_MUX, LSM_RD_MUX, RD_MUX, PC_MUX, DATA_MUX,
    input  REG_GATE_B, REG_GATE_C, IR, ALU_BUS, REG_COUNTER,
    output A_BUS, ST, PC
  );
endinterface

// File: rtl/reg_bank_encap.sv
// ARMv4 architectural register file: R0-R15 (R15 = PC). Combinational reads
// from stored contents (no bypass, no +8 offset), single-edge writes of ALU
// result or link value, and PC increment under controller command.
module reg_bank_encap #(
  parameter logic [31:0] START_ADDRESS = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  reg_bank_encap_if.slave   bus,
  output wire  [31:0]       B_BUS,
  output wire  [31:0]       C_BUS
);

  localparam logic [3:0] LINK_IDX = 4'd14;
  localparam logic [3:0] PC_IDX   = 4'd15;

  logic [31:0] regs_q [16];
  logic [31:0] regs_d [16];
  logic [3:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  b_idx;

  // Only Rn, Rd, Rs and Rm fields of the instruction address this bank.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{bus.IR[31:20], bus.IR[7:4]};

  // Destination select (LSM counter > link > Rn > Rd) and write data select.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and no latch is inferred.
    wr_idx  = bus.IR[15:12];
    wr_data = bus.DATA_MUX ? regs_q[PC_IDX] : bus.ALU_BUS;
    if (bus.LSM_RD_MUX) begin
      wr_idx = bus.REG_COUNTER;
    end else if (bus.IR_RD_MUX) begin
      wr_idx = LINK_IDX;
    end else if (bus.RD_MUX) begin
      wr_idx = bus.IR[19:16];
    end
  end

  // Next register contents: PC increment first, so a write to R15 overrides it.
  always_comb begin
    // NOTE: blocking assignments here model ordered combinational evaluation; the later write to R15 wins.
    for (int i = 0; i < 16; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (bus.PC_MUX) begin
      regs_d[PC_IDX] = regs_q[PC_IDX] + 32'd4;
    end
    if (bus.LATCH_REG) begin
      regs_d[wr_idx] = wr_data;
    end
  end

  // Register state; reset clears R0-R14 and loads the start address into R15.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: this small array is flops, not RAM, so it is reset architecturally; state updates use non-blocking assignments.
    if (rst) begin
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= '0;
      end
      regs_q[PC_IDX] <= START_ADDRESS;
    end else begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // B read index: LSM counter > Rd (store data) > Rm.
  always_comb begin
    b_idx = bus.IR[3:0];
    if (bus.LSM_RD_MUX) begin
      b_idx = bus.REG_COUNTER;
    end else if (bus.IR_RD_MUX) begin
      b_idx = bus.IR[15:12];
    end
  end

  assign bus.A_BUS = regs_q[bus.IR[19:16]];
  assign bus.ST    = regs_q[bus.IR[15:12]];
  assign bus.PC    = regs_q[PC_IDX];

  // B is shared with the multiplier; both tristate buses release when ungated.
  assign B_BUS = bus.REG_GATE_B ? regs_q[b_idx] : 32'hzzzz_zzzz;
  assign C_BUS = bus.REG_GATE_C ? regs_q[bus.IR[11:8]] : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_reg_bank_encap.sv
// Directed bench for reg_bank_encap: reset, PC increment/wrap, ALU and link
// writes, destination priority, tristate gating and mid-operation reset.
module tb_reg_bank_encap;

  localparam logic [31:0] MUL_B = 32'hCAFE_F00D;
  localparam logic [31:0] MUL_C = 32'h0BAD_0C0C;

  logic clk;
  logic rst;
  logic mul_b_en;
  logic mul_c_en;
  wire [31:0] b_bus;
  wire [31:0] c_bus;
  int passed;
  int total;

  reg_bank_encap_if rb ();

  reg_bank_encap #(.START_ADDRESS(32'h0000_0000)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (rb.slave),
    .B_BUS (b_bus),
    .C_BUS (c_bus)
  );

  // Stand-ins for the other bus drivers (external multiplier).
  assign b_bus = mul_b_en ? MUL_B : 32'hzzzz_zzzz;
  assign c_bus = mul_c_en ? MUL_C : 32'hzzzz_zzzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  function automatic logic [31:0] mk_ir(input logic [3:0] rn, input logic [3:0] rd,
                                        input logic [3:0] rs, input logic [3:0] rm);
    return {12'h000, rn, rd, rs, 4'h0, rm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rb.LATCH_REG   = 1'b0;
    rb.IR_RD_MUX   = 1'b0;
    rb.LSM_RD_MUX  = 1'b0;
    rb.RD_MUX      = 1'b0;
    rb.PC_MUX      = 1'b0;
    rb.DATA_MUX    = 1'b0;
    rb.REG_GATE_B  = 1'b0;
    rb.REG_GATE_C  = 1'b0;
    rb.REG_COUNTER = 4'h0;
    rb.ALU_BUS     = 32'h0;
  endtask

  // Write val into register idx through the Rd path.
  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    idle();
    rb.IR        = mk_ir(4'h0, idx, 4'h0, 4'h0);
    rb.ALU_BUS   = val;
    rb.LATCH_REG = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    rb.IR = mk_ir(4'h0, 4'h0, 4'h0, 4'h0);
    mul_b_en = 1'b1;
    mul_c_en = 1'b1;
    #1;
    total++; if (rb.PC !== 32'h0) $display("FAIL reset_pc: got %h required %h", rb.PC, 32'h0); else passed++;
    total++; if (rb.A_BUS !== 32'h0) $display("FAIL reset_a: got %h required %h", rb.A_BUS, 32'h0); else passed++;
    total++; if (rb.ST !== 32'h0) $display("FAIL reset_st: got %h required %h", rb.ST, 32'h0); else passed++;
    total++; if (b_bus !== MUL_B) $display("FAIL reset_b_released: got %h required %h", b_bus, MUL_B); else passed++;
    total++; if (c_bus !== MUL_C) $display("FAIL reset_c_released: got %h required %h", c_bus, MUL_C); else passed++;
    mul_b_en = 1'b0;
    mul_c_en = 1'b0;
    #1 rst = 1'b0;
    tick();
  endtask

  task automatic test_increment();
    logic [31:0] exp_pc;
    idle();
    rb.PC_MUX = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_pc = 32'(i * 4);
      total++; if (rb.PC !== exp_pc) $display("FAIL inc_step%0d: got %h required %h", i, rb.PC, exp_pc); else passed++;
    end
    preload(4'hF, 32'hFFFF_FFFC);
    total++; if (rb.PC !== 32'hFFFF_FFFC) $display("FAIL pc_preload: got %h required %h", rb.PC, 32'hFFFF_FFFC); else passed++;
    rb.PC_MUX = 1'b1;
    tick();
    total++; if (rb.PC !== 32'h0) $display("FAIL pc_wrap: got %h required %h", rb.PC, 32'h0); else passed++;
    rb.PC_MUX = 1'b0;
    tick();
    total++; if (rb.PC !== 32'h0) $display("FAIL pc_hold: got %h required %h", rb.PC, 32'h0); else passed++;
  endtask

  task automatic test_alu_write();
    idle();
    rb.IR        = mk_ir(4'h3, 4'h3, 4'h0, 4'h0);
    rb.ALU_BUS   = 32'hDEAD_BEEF;
    rb.LATCH_REG = 1'b1;
    #1;
    total++; if (rb.A_BUS !== 32'h0) $display("FAIL alu_pre_edge: got %h required %h", rb.A_BUS, 32'h0); else passed++;
    tick();
    idle();
    total++; if (rb.A_BUS !== 32'hDEAD_BEEF) $display("FAIL alu_a: got %h required %h", rb.A_BUS, 32'hDEAD_BEEF); else passed++;
    total++; if (rb.ST !== 32'hDEAD_BEEF) $display("FAIL alu_st: got %h required %h", rb.ST, 32'hDEAD_BEEF); else passed++;
  endtask

  task automatic test_rd_mux();
    idle();
    rb.IR        = mk_ir(4'h9, 4'h2, 4'h0, 4'h0);
    rb.RD_MUX    = 1'b1;
    rb.ALU_BUS   = 32'h0000_0099;
    rb.LATCH_REG = 1'b1;
    tick();
    idle();
    total++; if (rb.A_BUS !== 32'h99) $display("FAIL rdmux_rn: got %h required %h", rb.A_BUS, 32'h99); else passed++;
    total++; if (rb.ST !== 32'h0) $display("FAIL rdmux_rd_untouched: got %h required %h", rb.ST, 32'h0); else passed++;
  endtask

  task automatic test_link();
    preload(4'hF, 32'h0000_0100);
    rb.IR        = mk_ir(4'hE, 4'h3, 4'h0, 4'h0);
    rb.IR_RD_MUX = 1'b1;
    rb.DATA_MUX  = 1'b1;
    rb.LATCH_REG = 1'b1;
    rb.PC_MUX    = 1'b1;
    tick();
    idle();
    total++; if (rb.PC !== 32'h104) $display("FAIL link_pc: got %h required %h", rb.PC, 32'h104); else passed++;
    total++; if (rb.A_BUS !== 32'h100) $display("FAIL link_r14: got %h required %h", rb.A_BUS, 32'h100); else passed++;
    total++; if (rb.ST !== 32'hDEAD_BEEF) $display("FAIL link_rd_untouched: got %h required %h", rb.ST, 32'hDEAD_BEEF); else passed++;
  endtask

  task automatic test_pc_priority();
    idle();
    rb.IR        = mk_ir(4'h0, 4'hF, 4'h0, 4'h0);
    rb.ALU_BUS   = 32'h0000_2000;
    rb.LATCH_REG = 1'b1;
    rb.PC_MUX    = 1'b1;
    tick();
    idle();
    total++; if (rb.PC !== 32'h2000) $display("FAIL pc_priority: got %h required %h", rb.PC, 32'h2000); else passed++;
  endtask

  task automatic test_back_to_back();
    idle();
    rb.LATCH_REG = 1'b1;
    rb.IR        = mk_ir(4'h5, 4'h5, 4'h0, 4'h0);
    rb.ALU_BUS   = 32'h0000_0055;
    tick();
    total++; if (rb.A_BUS !== 32'h55) $display("FAIL b2b_first: got %h required %h", rb.A_BUS, 32'h55); else passed++;
    rb.IR      = mk_ir(4'h5, 4'h7, 4'h0, 4'h0);
    rb.ALU_BUS = 32'h0000_0077;
    tick();
    idle();
    total++; if (rb.ST !== 32'h77) $display("FAIL b2b_second: got %h required %h", rb.ST, 32'h77); else passed++;
    total++; if (rb.A_BUS !== 32'h55) $display("FAIL b2b_first_kept: got %h required %h", rb.A_BUS, 32'h55); else passed++;
  endtask

  task automatic test_gating();
    idle();
    rb.IR         = mk_ir(4'h0, 4'h3, 4'h5, 4'h7);
    rb.REG_GATE_B = 1'b1;
    rb.REG_GATE_C = 1'b1;
    #1;
    total++; if (b_bus !== 32'h77) $display("FAIL gate_b_rm: got %h required %h", b_bus, 32'h77); else passed++;
    total++; if (c_bus !== 32'h55) $display("FAIL gate_c_rs: got %h required %h", c_bus, 32'h55); else passed++;
    rb.IR_RD_MUX = 1'b1;
    #1;
    total++; if (b_bus !== 32'hDEAD_BEEF) $display("FAIL gate_b_rd: got %h required %h", b_bus, 32'hDEAD_BEEF); else passed++;
    rb.LSM_RD_MUX  = 1'b1;
    rb.REG_COUNTER = 4'h5;
    #1;
    total++; if (b_bus !== 32'h55) $display("FAIL gate_b_lsm: got %h required %h", b_bus, 32'h55); else passed++;
    rb.REG_GATE_B = 1'b0;
    rb.REG_GATE_C = 1'b0;
    mul_b_en = 1'b1;
    mul_c_en = 1'b1;
    #1;
    total++; if (b_bus !== MUL_B) $display("FAIL gate_b_off: got %h required %h", b_bus, MUL_B); else passed++;
    total++; if (c_bus !== MUL_C) $display("FAIL gate_c_off: got %h required %h", c_bus, MUL_C); else passed++;
    mul_b_en = 1'b0;
    mul_c_en = 1'b0;
    idle();
  endtask

  task automatic test_lsm_write();
    idle();
    rb.IR          = mk_ir(4'hB, 4'hE, 4'h0, 4'h0);
    rb.LSM_RD_MUX  = 1'b1;
    rb.IR_RD_MUX   = 1'b1;
    rb.REG_COUNTER = 4'hB;
    rb.ALU_BUS     = 32'h0000_000B;
    rb.LATCH_REG   = 1'b1;
    tick();
    idle();
    total++; if (rb.A_BUS !== 32'hB) $display("FAIL lsm_write: got %h required %h", rb.A_BUS, 32'hB); else passed++;
    total++; if (rb.ST !== 32'h100) $display("FAIL lsm_r14_untouched: got %h required %h", rb.ST, 32'h100); else passed++;
  endtask

  task automatic test_reset_mid();
    idle();
    rb.IR        = mk_ir(4'h4, 4'h4, 4'h0, 4'h0);
    rb.ALU_BUS   = 32'h0000_0044;
    rb.LATCH_REG = 1'b1;
    rb.PC_MUX    = 1'b1;
    #2 rst = 1'b1;
    #1;
    total++; if (rb.PC !== 32'h0) $display("FAIL mid_reset_pc: got %h required %h", rb.PC, 32'h0); else passed++;
    tick();
    total++; if (rb.A_BUS !== 32'h0) $display("FAIL mid_reset_write_ignored: got %h required %h", rb.A_BUS, 32'h0); else passed++;
    total++; if (rb.PC !== 32'h0) $display("FAIL mid_reset_inc_ignored: got %h required %h", rb.PC, 32'h0); else passed++;
    rst = 1'b0;
    tick();
    idle();
    total++; if (rb.A_BUS !== 32'h44) $display("FAIL post_reset_write: got %h required %h", rb.A_BUS, 32'h44); else passed++;
    total++; if (rb.PC !== 32'h4) $display("FAIL post_reset_inc: got %h required %h", rb.PC, 32'h4); else passed++;
  endtask

  initial begin
    passed   = 0;
    total    = 0;
    rst      = 1'b0;
    mul_b_en = 1'b0;
    mul_c_en = 1'b0;
    rb.IR    = 32'h0;
    idle();
    test_reset();
    test_increment();
    test_alu_write();
    test_rd_mux();
    test_link();
    test_pc_priority();
    test_back_to_back();
    test_gating();
    test_lsm_write();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
